// File: rtl/gprmc_encode.sv
// ============================================================================
//  Module      : gprmc_encode
//  Description : Builds a 34-byte NMEA $GPRMC sentence from a BCD time of day
//                and paces it out byte by byte on the uart_tx pi_data/pi_flag
//                interface.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gprmc_encode #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 9600
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [23:0] time_bcd,
  input  logic        fix_valid,
  output logic [7:0]  pi_data,
  output logic        pi_flag,
  output logic        busy,
  output logic        done
);

  // Ten bit times per frame plus one bit of guard, since uart_tx has no ready.
  localparam int BYTE_CYCLES = (CLK_FREQ / UART_BPS) * 11;
  localparam int C_CNT_W     = $clog2(BYTE_CYCLES);

  localparam logic [C_CNT_W-1:0] C_GAP_LOAD = C_CNT_W'(BYTE_CYCLES - 2);
  localparam logic [5:0]         C_LAST_IDX = 6'd33;
  localparam logic [5:0]         C_CS_FIRST = 6'd1;
  localparam logic [5:0]         C_CS_LAST  = 6'd28;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [5:0]           r_idx;
  logic [5:0]           w_idx_nxt;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [C_CNT_W-1:0]   w_cnt_nxt;
  logic [7:0]           r_csum;
  logic [7:0]           w_csum_nxt;
  logic [23:0]          r_time;
  logic [23:0]          w_time_nxt;
  logic                 r_fix;
  logic                 w_fix_nxt;
  logic [7:0]           w_byte;

  logic [7:0]           r_pi_data;
  logic                 r_pi_flag;
  logic                 r_busy;
  logic                 r_done;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    hex_ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  function automatic logic [7:0] digit_ascii(input logic [3:0] nib);
    digit_ascii = 8'h30 + {4'h0, nib};
  endfunction

  // Next-state logic. The checksum absorbs the byte currently on pi_data.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_csum_nxt  = r_csum;
    w_time_nxt  = r_time;
    w_fix_nxt   = r_fix;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SEND;
          w_idx_nxt   = 6'd0;
          w_csum_nxt  = 8'h00;
          w_time_nxt  = time_bcd;
          w_fix_nxt   = fix_valid;
        end
      end
      S_SEND: begin
        if ((r_idx >= C_CS_FIRST) && (r_idx <= C_CS_LAST)) begin
          w_csum_nxt = r_csum ^ r_pi_data;
        end
        w_cnt_nxt   = C_GAP_LOAD;
        w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          if (r_idx == C_LAST_IDX) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx + 6'd1;
            w_state_nxt = S_SEND;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Byte for the index about to be sent; registered so it appears with pi_flag.
  always_comb begin
    w_byte = 8'h00;
    case (w_idx_nxt)
      6'd0:  w_byte = 8'h24;                        // '$'
      6'd1:  w_byte = 8'h47;                        // 'G'
      6'd2:  w_byte = 8'h50;                        // 'P'
      6'd3:  w_byte = 8'h52;                        // 'R'
      6'd4:  w_byte = 8'h4D;                        // 'M'
      6'd5:  w_byte = 8'h43;                        // 'C'
      6'd7:  w_byte = digit_ascii(w_time_nxt[23:20]);
      6'd8:  w_byte = digit_ascii(w_time_nxt[19:16]);
      6'd9:  w_byte = digit_ascii(w_time_nxt[15:12]);
      6'd10: w_byte = digit_ascii(w_time_nxt[11:8]);
      6'd11: w_byte = digit_ascii(w_time_nxt[7:4]);
      6'd12: w_byte = digit_ascii(w_time_nxt[3:0]);
      6'd13: w_byte = 8'h2E;                        // '.'
      6'd14, 6'd15: w_byte = 8'h30;
      6'd17: w_byte = w_fix_nxt ? 8'h41 : 8'h56;   // 'A' / 'V'
      6'd6, 6'd16, 6'd18, 6'd19, 6'd20, 6'd21, 6'd22,
      6'd23, 6'd24, 6'd25, 6'd26, 6'd27: w_byte = 8'h2C;
      6'd28: w_byte = 8'h4E;                        // 'N'
      6'd29: w_byte = 8'h2A;                        // '*'
      6'd30: w_byte = hex_ascii(w_csum_nxt[7:4]);
      6'd31: w_byte = hex_ascii(w_csum_nxt[3:0]);
      6'd32: w_byte = 8'h0D;
      6'd33: w_byte = 8'h0A;
      default: w_byte = 8'h00;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= 6'd0;
      r_cnt     <= '0;
      r_csum    <= 8'h00;
      r_time    <= 24'h000000;
      r_fix     <= 1'b0;
      r_pi_data <= 8'h00;
      r_pi_flag <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_csum    <= w_csum_nxt;
      r_time    <= w_time_nxt;
      r_fix     <= w_fix_nxt;
      r_pi_flag <= (w_state_nxt == S_SEND);
      r_busy    <= (w_state_nxt == S_SEND) || (w_state_nxt == S_GAP);
      r_done    <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_SEND) begin
        r_pi_data <= w_byte;
      end
    end
  end

  assign pi_data = r_pi_data;
  assign pi_flag = r_pi_flag;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_gprmc_encode.sv
// ============================================================================
//  Module      : tb_gprmc_encode
//  Description : Self-checking bench for gprmc_encode (BYTE_CYCLES = 110).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gprmc_encode;

  localparam int BC = 110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] time_bcd = 24'h0;
  logic        fix_valid = 1'b0;
  logic [7:0]  pi_data;
  logic        pi_flag;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int mk;
  logic [7:0] exp_b [34];

  typedef struct {
    logic [23:0] t;
    bit          fix;
    string       exp;
  } vec_t;

  vec_t tbl [5];

  gprmc_encode #(.CLK_FREQ(96000), .UART_BPS(9600)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .start     (start),
    .time_bcd  (time_bcd),
    .fix_valid (fix_valid),
    .pi_data   (pi_data),
    .pi_flag   (pi_flag),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic push(input logic [7:0] b);
    if (mk < 34) exp_b[mk] = b;
    mk++;
  endtask

  // Reference sentence built from the textual rules of the NMEA format.
  task automatic model(input logic [23:0] t, input bit fix);
    string hx;
    string s1;
    string s2;
    logic [7:0] cs;
    hx = "0123456789ABCDEF";
    s1 = "$GPRMC,";
    s2 = ",,,,,,,,,,N";
    mk = 0;
    for (int i = 0; i < s1.len(); i++) push(s1[i]);
    for (int n = 5; n >= 0; n--) push(8'h30 + {4'h0, t[n*4 +: 4]});
    push(".");
    push("0");
    push("0");
    push(",");
    push(fix ? "A" : "V");
    for (int i = 0; i < s2.len(); i++) push(s2[i]);
    cs = 8'h00;
    for (int i = 1; i < mk; i++) cs ^= exp_b[i];
    push("*");
    push(hx[cs[7:4]]);
    push(hx[cs[3:0]]);
    push(8'h0D);
    push(8'h0A);
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < 34; i++) exp_b[i] = s[i];
  endtask

  // mode 1 re-issues start with a new time shortly after byte 10.
  task automatic run_sentence(input logic [23:0] t, input bit fix, input int mode,
                              input string nm);
    logic [7:0] got_d [$];
    int got_c [$];
    int t0;
    int dcyc;
    int busy_err;
    bit seen;
    @(negedge clk);
    time_bcd = t;
    fix_valid = fix;
    start = 1'b1;
    t0 = cyc;
    dcyc = -1;
    busy_err = 0;
    seen = 1'b0;
    for (int i = 0; i < 34*BC + 50 && !seen; i++) begin
      @(negedge clk);
      start = (mode == 1) && (cyc == t0 + 1 + 10*BC + 5);
      if (start) time_bcd = 24'h235959;
      if (pi_flag) begin
        got_d.push_back(pi_data);
        got_c.push_back(cyc);
      end
      if (busy !== ((cyc >= t0 + 1) && (cyc <= t0 + 34*BC))) busy_err++;
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
    start = 1'b0;
    chk({nm, " done_cycle"}, dcyc, t0 + 1 + 34*BC);
    chk({nm, " strobe_count"}, got_d.size(), 34);
    for (int k = 0; k < got_d.size() && k < 34; k++) begin
      chk($sformatf("%s byte%0d", nm, k), {24'h0, got_d[k]}, {24'h0, exp_b[k]});
      chk($sformatf("%s strobe%0d_cycle", nm, k), got_c[k], t0 + 1 + k*BC);
    end
    chk({nm, " busy_window_errors"}, busy_err, 0);
  endtask

  initial begin
    int nst;
    tbl[0] = '{t: 24'h123456, fix: 1'b1, exp: "$GPRMC,123456.00,A,,,,,,,,,,N*6D\r\n"};
    tbl[1] = '{t: 24'h000000, fix: 1'b0, exp: "$GPRMC,000000.00,V,,,,,,,,,,N*7D\r\n"};
    for (int i = 2; i < 5; i++) begin
      tbl[i].t = 24'($urandom);
      tbl[i].fix = 1'($urandom_range(0, 1));
      tbl[i].exp = "";
    end

    repeat (3) @(negedge clk);
    chk("reset pi_data", {24'h0, pi_data}, 0);
    chk("reset pi_flag", {31'h0, pi_flag}, 0);
    chk("reset busy", {31'h0, busy}, 0);
    chk("reset done", {31'h0, done}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Consecutive entries start the cycle after the previous done.
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].exp != "") load_str(tbl[i].exp);
      else model(tbl[i].t, tbl[i].fix);
      run_sentence(tbl[i].t, tbl[i].fix, 0, $sformatf("vec%0d", i));
    end

    // Restart attempt mid-sentence must be ignored.
    model(24'h123456, 1'b1);
    run_sentence(24'h123456, 1'b1, 1, "ignore_start");
    nst = 0;
    repeat (300) begin
      @(negedge clk);
      if (pi_flag) nst++;
    end
    chk("ignore_start no_extra_strobes", nst, 0);

    // Asynchronous reset during byte 15's gap.
    @(negedge clk);
    time_bcd = 24'h123456;
    fix_valid = 1'b1;
    start = 1'b1;
    nst = 0;
    for (int i = 0; i < 20*BC && nst < 16; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (pi_flag) nst++;
    end
    repeat (20) @(negedge clk);
    chk("pre_reset busy", {31'h0, busy}, 1);
    chk("pre_reset pi_data", {24'h0, pi_data}, 32'h30);
    rst_n = 1'b0;
    #1;
    chk("midreset pi_data", {24'h0, pi_data}, 0);
    chk("midreset pi_flag", {31'h0, pi_flag}, 0);
    chk("midreset busy", {31'h0, busy}, 0);
    chk("midreset done", {31'h0, done}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nst = 0;
    repeat (500) begin
      @(negedge clk);
      if (pi_flag || busy) nst++;
    end
    chk("post_reset quiet_cycles_active", nst, 0);
    model(24'h095817, 1'b1);
    run_sentence(24'h095817, 1'b1, 0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gprmc_encode.md
Name: gprmc_encode

Overview:
- Generates an NMEA $GPRMC sentence from a BCD time-of-day and emits it byte by byte on the pi_data/pi_flag interface of the team's uart_tx.
- It is the transmit-side counterpart of the GPS receive path (uart_rx -> GPRMC_decode).
- It is used as an on-board GPS sentence source, for loopback test of the time-display chain and for echoing time back to a host.
- Bytes are paced internally by a counter, because uart_tx has no ready signal.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- UART_BPS, 9600, downstream UART baud rate.
- BYTE_CYCLES, (CLK_FREQ/UART_BPS)*11, clocks between successive pi_flag pulses: 10 bit times plus 1 bit of guard. This is a localparam.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst_n  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle request to send a sentence. Sampled only in IDLE.
- time_bcd  in  24  time as H1 H0 M1 M0 S1 S0, 4 bits each, MSB first.
- fix_valid  in  1  1 -> status 'A'; 0 -> status 'V'.
- pi_data  out  8  ASCII byte to uart_tx.
- pi_flag  out  1  one-cycle strobe; pi_data is valid in the same cycle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the sentence is complete.

Behaviour:
- Reset: pi_data=8'h00, pi_flag=0, busy=0, done=0, state=IDLE, byte index=0, checksum=0, pacing counter=0. Reset is asynchronous and takes effect mid-sentence. The partial sentence is abandoned, and no resume occurs after reset is released.
- Sentence is fixed at 34 bytes, index 0..33: "$GPRMC,HHMMSS.00,S,,,,,,,,,,N*CC\r\n".
  - Ten commas sit between S and N.
  - Digits are emitted as 8'h30 + nibble, with no range check.
  - S is 'A' or 'V'.
  - CC is the XOR of bytes 1..28 (everything strictly between '$' and '*'), written as two uppercase hex ASCII characters, high nibble first.
- States:
  - IDLE: if start=1, latch time_bcd and fix_valid, clear the checksum, set index=0, and go to SEND.
  - SEND: drive pi_data = byte[index] and pulse pi_flag for 1 cycle. XOR the byte into the checksum when 1<=index<=28. Load the pacing counter and go to GAP.
  - GAP: count BYTE_CYCLES-1 cycles. Then, if index==33 go to DONE; else increment index and go to SEND.
  - DONE: pulse done for 1 cycle, drop busy, and go to IDLE.
- Timing: start is accepted at cycle T.
  - Byte k strobes at cycle T+1+k*BYTE_CYCLES.
  - done occurs at T+1+34*BYTE_CYCLES.
  - busy is high during cycles T+1 through T+34*BYTE_CYCLES.
- The checksum bytes (indices 30, 31) use the fully accumulated value. Index 28 is XORed before index 30 is formed, and the GAP guarantees this.
- start while busy is ignored; the request is not queued. Input changes during a sentence have no effect, because the inputs were latched at start.
- start in the same cycle as done cannot be accepted, since the state is not IDLE; it must be reissued.
- pi_data holds its last value between strobes.

Test Plan:
- Bench overrides: CLK_FREQ=96000 and UART_BPS=9600, giving BYTE_CYCLES=110.
- Test 1: time_bcd=24'h123456, fix_valid=1, start pulse.
  - Required: 34 strobes exactly 110 cycles apart.
  - Required bytes: "$GPRMC,123456.00,A,,,,,,,,,,N*6D\r\n".
  - Required: done at T+1+3740.
- Test 2: time_bcd=24'h000000, fix_valid=0. Required: "$GPRMC,000000.00,V,,,,,,,,,,N*7D\r\n".
- Test 3: second start at byte 10, with time_bcd changed to 24'h235959. Required: still exactly 34 bytes carrying the original time, and no extra sentence.
- Test 4: sys_rst_n=0 for 3 cycles during byte 15's GAP. Required:
  - All outputs return to reset values immediately.
  - No pi_flag until the next start.
  - A new start produces a complete, correct sentence.
- Test 5: two sentences back-to-back, with start issued the cycle after done. Required: the second sentence begins at that start+1, and the checksums are independent, so no carry-over.
- Test 6: loopback of gprmc_encode -> uart_tx -> uart_rx -> GPRMC_decode at the default parameters. Required: final_time reflects 12:34:56 after one sentence.
